mem_arbiter_6502: RTL

Single-port synchronous memory arbiter that shares the 64 KB system RAM between the 6502 core and a secondary DMA/loader requester. It sits between `cpu_6502` and the RAM and drives the core's `RDY` to stall it while DMA beats are served. It also holds the core's read data stable across stalls. DMA bursts are bounded so the CPU always regains the port.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_6502.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Purpose: shared types for the 6502 / DMA single-port RAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  // Port ownership for the current cycle.
  typedef enum logic [0:0] {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } arb_state_t;

  // Who the RAM read data returning next cycle belongs to.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    CPU    = 2'd1,
    DMA_RD = 2'd2
  } rd_src_t;

endpackage

// File: rtl/mem_arbiter_6502.sv
// Purpose: shares one registered-read RAM port between the 6502 core and a DMA/loader requester.
// Latency: DMA grant one cycle after dma_req seen in a CPU cycle; read data (CPU or DMA) one cycle after the access.
// Backpressure: CPU stalled via cpu_rdy while DMA owns the port; DMA holds dma_req until dma_ack, bursts capped at DMA_BURST_MAX.
module mem_arbiter_6502
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8,
  parameter int DMA_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  // 6502 core side
  input  logic [ADDR_W-1:0] cpu_ab,
  input  logic [DATA_W-1:0] cpu_do,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_di,
  output logic              cpu_rdy,
  // DMA / loader side
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_we,
  output logic              dma_ack,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  // RAM port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Counter wide enough to hold DMA_BURST_MAX-1 even when the maximum is 1.
  localparam int              CNT_W    = $clog2(DMA_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DMA_BURST_MAX - 1);

  arb_state_t        state, state_nxt;
  rd_src_t           rsrc, rsrc_nxt;
  logic [CNT_W-1:0]  burst_cnt, burst_cnt_nxt;
  logic [DATA_W-1:0] cpu_di_hold;
  logic              cpu_rdy_q;
  logic              dma_owner;
  logic              ack;

  assign dma_owner = (state == S_DMA);

  // A beat is accepted whenever DMA owns the port and is asking.
  always_comb begin
    ack = dma_owner & dma_req;
  end

  // RAM port mux; DMA side is gated by its request so an idle DMA cycle leaves RAM untouched.
  always_comb begin
    mem_en    = 1'b1;
    mem_we    = cpu_we;
    mem_addr  = cpu_ab;
    mem_wdata = cpu_do;
    if (dma_owner) begin
      mem_en    = dma_req;
      mem_we    = dma_req & dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
    // Never corrupt RAM while the system is held in reset.
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  // Ownership and burst length; DMA requests are only granted from a CPU cycle, so the CPU always gets a turn.
  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    case (state)
      S_CPU: begin
        if (dma_req) begin
          state_nxt     = S_DMA;
          burst_cnt_nxt = '0;
        end
      end
      S_DMA: begin
        if (!dma_req) begin
          state_nxt = S_CPU;
        end else begin
          burst_cnt_nxt = burst_cnt + CNT_W'(1);
          if (burst_cnt == CNT_LAST) begin
            state_nxt = S_CPU;
          end
        end
      end
      default: begin
        state_nxt = S_CPU;
      end
    endcase
  end

  // Tag the access issued this cycle so next cycle's RAM output can be routed.
  always_comb begin
    rsrc_nxt = NONE;
    if (state == S_CPU) begin
      rsrc_nxt = CPU;
    end else if (ack && !dma_we) begin
      rsrc_nxt = DMA_RD;
    end
  end

  // Arbiter state registers; reset drops any in-flight DMA read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_CPU;
      cpu_rdy_q <= 1'b1;
      burst_cnt <= '0;
      rsrc      <= NONE;
    end else begin
      state     <= state_nxt;
      cpu_rdy_q <= (state_nxt == S_CPU);
      burst_cnt <= burst_cnt_nxt;
      rsrc      <= rsrc_nxt;
    end
  end

  // Capture the CPU's last read so DI stays stable while the core is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_di_hold <= '0;
    end else if (rsrc == CPU) begin
      cpu_di_hold <= mem_rdata;
    end
  end

  assign cpu_rdy    = cpu_rdy_q;
  assign dma_ack    = ack;
  assign cpu_di     = (rsrc == CPU) ? mem_rdata : cpu_di_hold;
  assign dma_rvalid = (rsrc == DMA_RD);
  assign dma_rdata  = mem_rdata;

endmodule
